// File: rtl/axil_step_gen_pkg.sv
// Shared definitions for the AXI4-Lite step/dir generator: register map,
// CTRL bit positions, generator state encoding and a byte-strobe merge helper.
package axil_step_gen_pkg;

  localparam logic [4:0] OFF_PERIOD = 5'h00;
  localparam logic [4:0] OFF_WIDTH  = 5'h04;
  localparam logic [4:0] OFF_STEPS  = 5'h08;
  localparam logic [4:0] OFF_CTRL   = 5'h0C;
  localparam logic [4:0] OFF_REMAIN = 5'h10;

  localparam int CTRL_START = 0;
  localparam int CTRL_DIR   = 1;
  localparam int CTRL_ABORT = 2;
  localparam int CTRL_ERR   = 2;
  localparam int CTRL_BUSY  = 31;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW
  } state_e;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/step_pulse_fsm.sv
// Step/dir pulse generator: latches move parameters on START and emits
// REMAIN high/low step cycles, ending with a one-cycle done pulse.
module step_pulse_fsm
  import axil_step_gen_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        dir_i,
  input  logic [31:0] period_i,
  input  logic [31:0] width_i,
  input  logic [31:0] steps_i,
  output logic        step_o,
  output logic        dir_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] remain_o
);

  state_e      state_q;
  logic [31:0] cnt_q;
  logic [31:0] period_q;
  logic [31:0] width_q;
  logic [31:0] remain_q;
  logic        step_q;
  logic        dir_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        params_ok;

  assign params_ok = (steps_i != 32'd0) && (width_i != 32'd0) && (width_i < period_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      width_q  <= '0;
      remain_q <= '0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Abort overrides everything, including a START arriving in the same write.
      if (abort_i) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        remain_q <= '0;
        step_q   <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              if (params_ok) begin
                period_q <= period_i;
                width_q  <= width_i;
                remain_q <= steps_i;
                dir_q    <= dir_i;
                err_q    <= 1'b0;
                busy_q   <= 1'b1;
                state_q  <= SETUP;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          SETUP: begin
            cnt_q   <= '0;
            step_q  <= 1'b1;
            state_q <= HIGH;
          end
          HIGH: begin
            cnt_q <= cnt_q + 32'd1;
            if (cnt_q == width_q - 32'd1) begin
              step_q  <= 1'b0;
              state_q <= LOW;
            end
          end
          LOW: begin
            // One period counter spans the whole step: 0..WIDTH-1 high, WIDTH..PERIOD-1 low.
            if (cnt_q == period_q - 32'd1) begin
              cnt_q    <= '0;
              remain_q <= remain_q - 32'd1;
              if (remain_q == 32'd1) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= IDLE;
              end else begin
                step_q  <= 1'b1;
                state_q <= HIGH;
              end
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign step_o   = step_q;
  assign dir_o    = dir_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign remain_o = remain_q;

endmodule

// File: rtl/axil_step_gen.sv
// AXI4-Lite responder and shadow register file for one stepper channel;
// the pulse generator itself lives in step_pulse_fsm.
module axil_step_gen
  import axil_step_gen_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            step_o,
  output logic                            dir_o,
  output logic                            busy_o,
  output logic                            done_o
);

  logic        awready_q;
  logic        bvalid_q;
  logic        arready_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;
  logic [31:0] period_q;
  logic [31:0] width_q;
  logic [31:0] steps_q;
  logic        dir_q;
  logic        start_q;
  logic        abort_q;
  logic        wr_en;
  logic        rd_en;
  logic [4:0]  waddr;
  logic [4:0]  raddr;
  logic        gen_busy;
  logic        gen_err;
  logic [31:0] gen_remain;
  logic        unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign waddr = {S_AXI_AWADDR[4:2], 2'b00};
  assign raddr = {S_AXI_ARADDR[4:2], 2'b00};
  assign wr_en = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_en = arready_q & S_AXI_ARVALID;

  always_comb begin
    rdata_d = '0;
    case (raddr)
      OFF_PERIOD: rdata_d = period_q;
      OFF_WIDTH:  rdata_d = width_q;
      OFF_STEPS:  rdata_d = steps_q;
      OFF_CTRL: begin
        rdata_d[CTRL_BUSY] = gen_busy;
        rdata_d[CTRL_ERR]  = gen_err;
        rdata_d[CTRL_DIR]  = dir_q;
      end
      OFF_REMAIN: rdata_d = gen_remain;
      default:    rdata_d = '0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      period_q  <= '0;
      width_q   <= '0;
      steps_q   <= '0;
      dir_q     <= 1'b0;
      start_q   <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      // AWREADY/WREADY form a single-cycle pulse; BVALID blocks the next one.
      awready_q <= ~awready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
      arready_q <= ~arready_q & S_AXI_ARVALID & ~rvalid_q;
      start_q   <= 1'b0;
      abort_q   <= 1'b0;

      if (wr_en) begin
        bvalid_q <= 1'b1;
        case (waddr)
          OFF_PERIOD: period_q <= apply_wstrb(period_q, S_AXI_WDATA, S_AXI_WSTRB);
          OFF_WIDTH:  width_q  <= apply_wstrb(width_q, S_AXI_WDATA, S_AXI_WSTRB);
          OFF_STEPS:  steps_q  <= apply_wstrb(steps_q, S_AXI_WDATA, S_AXI_WSTRB);
          OFF_CTRL: begin
            if (S_AXI_WSTRB[0]) begin
              dir_q   <= S_AXI_WDATA[CTRL_DIR];
              start_q <= S_AXI_WDATA[CTRL_START];
              abort_q <= S_AXI_WDATA[CTRL_ABORT];
            end
          end
          default: ;
        endcase
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end

      if (rd_en) begin
        rdata_q  <= rdata_d;
        rvalid_q <= 1'b1;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_q;
  assign busy_o        = gen_busy;

  step_pulse_fsm u_gen (
    .clk_i    (ACLK),
    .rst_i    (ARESET),
    .start_i  (start_q),
    .abort_i  (abort_q),
    .dir_i    (dir_q),
    .period_i (period_q),
    .width_i  (width_q),
    .steps_i  (steps_q),
    .step_o   (step_o),
    .dir_o    (dir_o),
    .busy_o   (gen_busy),
    .done_o   (done_o),
    .err_o    (gen_err),
    .remain_o (gen_remain)
  );

endmodule

// File: tb/tb_axil_step_gen.sv
// Bench for axil_step_gen: single-beat AXI4-Lite master tasks feed expected
// read data / write responses to a queue-based monitor; step/dir timing is sampled directly.
module tb_axil_step_gen;

  logic        aclk = 1'b0;
  logic        areset;
  logic [4:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [4:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        step_o;
  logic        dir_o;
  logic        busy_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc = 0;
  logic [31:0] exp_r[$];
  logic [1:0]  exp_b[$];

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  axil_step_gen dut (
    .ACLK          (aclk),
    .ARESET        (areset),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .step_o        (step_o),
    .dir_o         (dir_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Response monitor: every completed R/B handshake is matched against the queues.
  always @(negedge aclk) begin
    if (rvalid && rready) begin
      checks++;
      if (exp_r.size() == 0) begin
        errors++;
        $display("FAIL rdata_unexpected: got 0x%08h, expected no response", rdata);
      end else begin
        logic [31:0] e;
        e = exp_r.pop_front();
        if (rdata !== e || rresp !== 2'b00) begin
          errors++;
          $display("FAIL rdata: got 0x%08h resp %0d, expected 0x%08h resp 0", rdata, rresp, e);
        end
      end
    end
    if (bvalid && bready) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL bresp_unexpected: got resp %0d, expected no response", bresp);
      end else begin
        logic [1:0] eb;
        eb = exp_b.pop_front();
        if (bresp !== eb) begin
          errors++;
          $display("FAIL bresp: got %0d, expected %0d", bresp, eb);
        end
      end
    end
  end

  task automatic issue_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(posedge aclk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!awready && n < 50);
    if (!awready) timeout_fail("aw_accept");
    else begin
      exp_b.push_back(2'b00);
      @(posedge aclk); #1;
      hs_cyc = cyc;
    end
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic wait_b();
    int n;
    n = 0;
    do begin @(negedge aclk); n++; end while (!bvalid && n < 50);
    if (!bvalid) timeout_fail("bvalid");
    else begin @(posedge aclk); #1; end
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d);
    issue_write(a, d, 4'hF);
    wait_b();
  endtask

  task automatic read_hold(input logic [4:0] a);
    int n;
    @(posedge aclk); #1;
    araddr = a; arvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!arready && n < 50);
    if (!arready) timeout_fail("ar_accept");
    else begin @(posedge aclk); #1; end
    arvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, input logic [31:0] e);
    int n;
    @(posedge aclk); #1;
    araddr = a; arvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!arready && n < 50);
    if (!arready) begin
      timeout_fail("ar_accept");
      arvalid = 1'b0;
    end else begin
      exp_r.push_back(e);
      @(posedge aclk); #1;
      arvalid = 1'b0;
      n = 0;
      do begin @(negedge aclk); n++; end while (!rvalid && n < 50);
      if (!rvalid) timeout_fail("rvalid");
      else begin @(posedge aclk); #1; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises, first_rise, done_cnt, done_at, last_fall, run;
    int min_hi, max_hi, min_lo, max_lo;
    logic prev, bad_dir, bad_step, bad_busy, bad_done, bad_hold;

    areset = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b1; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("reset_outputs", {23'd0, awready, wready, bvalid, arready, rvalid, step_o, dir_o, busy_o, done_o}, 32'd0);
    check("reset_resp", {28'd0, bresp, rresp}, 32'd0);
    areset = 1'b0;
    axi_read(5'h00, 32'd0);
    axi_read(5'h0C, 32'd0);
    axi_read(5'h10, 32'd0);

    // Register readback and unmapped offsets
    axi_write(5'h00, 32'd1);
    axi_write(5'h04, 32'd2);
    axi_write(5'h08, 32'd3);
    axi_write(5'h0C, 32'h2);
    axi_read(5'h00, 32'd1);
    axi_read(5'h04, 32'd2);
    axi_read(5'h08, 32'd3);
    axi_read(5'h0C, 32'h2);
    axi_write(5'h18, 32'hDEAD_BEEF);
    axi_read(5'h14, 32'd0);
    axi_read(5'h18, 32'd0);
    axi_read(5'h00, 32'd1);
    check("idle_no_busy", {31'd0, busy_o}, 32'd0);

    // Byte strobes
    axi_write(5'h00, 32'hFFFF_FFFF);
    issue_write(5'h00, 32'h0000_0012, 4'b0001);
    wait_b();
    axi_read(5'h00, 32'hFFFF_FF12);
    issue_write(5'h08, 32'hAABB_CCDD, 4'b1010);
    wait_b();
    axi_read(5'h08, 32'hAA00_CC03);

    // Normal move: 4 steps, 3 high / 7 low, DIR=1
    axi_write(5'h00, 32'd10);
    axi_write(5'h04, 32'd3);
    axi_write(5'h08, 32'd4);
    axi_write(5'h0C, 32'h3);
    check("move_t1_busy_dir_step", {29'd0, busy_o, dir_o, step_o}, 32'b110);
    rises = 0; first_rise = -1; done_cnt = 0; done_at = -1; last_fall = -1; run = 0;
    min_hi = 1000; max_hi = 0; min_lo = 1000; max_lo = 0; prev = 1'b0; bad_dir = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge aclk); #1;
      if (step_o != prev) begin
        if (prev) begin
          if (run < min_hi) min_hi = run;
          if (run > max_hi) max_hi = run;
          last_fall = cyc - hs_cyc;
        end else if (rises > 0) begin
          if (run < min_lo) min_lo = run;
          if (run > max_lo) max_lo = run;
        end
        if (step_o) begin
          rises++;
          if (rises == 1) first_rise = cyc - hs_cyc;
        end
        run = 1;
      end else begin
        run++;
      end
      prev = step_o;
      if (done_o) begin done_cnt++; done_at = cyc - hs_cyc; end
      if (busy_o && !dir_o) bad_dir = 1'b1;
    end
    check("move_pulses", rises, 4);
    check("move_first_rise", first_rise, 2);
    check("move_high_min", min_hi, 3);
    check("move_high_max", max_hi, 3);
    check("move_low_min", min_lo, 7);
    check("move_low_max", max_lo, 7);
    check("move_done_count", done_cnt, 1);
    check("move_done_at", done_at, 42);
    check("move_done_after_fall", done_at - last_fall, 7);
    check("move_dir_held", {31'd0, bad_dir}, 32'd0);
    check("move_idle_after", {30'd0, busy_o, step_o}, 32'd0);
    axi_read(5'h10, 32'd0);
    axi_read(5'h0C, 32'h2);

    // Invalid start: WIDTH == PERIOD
    axi_write(5'h04, 32'd10);
    axi_write(5'h00, 32'd10);
    axi_write(5'h0C, 32'h1);
    bad_step = 1'b0; bad_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge aclk); #1;
      if (step_o) bad_step = 1'b1;
      if (busy_o) bad_busy = 1'b1;
    end
    check("invalid_no_step", {31'd0, bad_step}, 32'd0);
    check("invalid_no_busy", {31'd0, bad_busy}, 32'd0);
    axi_read(5'h0C, 32'h4);

    // Abort after three pulses
    axi_write(5'h00, 32'd8);
    axi_write(5'h04, 32'd2);
    axi_write(5'h08, 32'd100);
    axi_write(5'h0C, 32'h1);
    axi_read(5'h0C, 32'h8000_0000);
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge aclk); #1;
      if (step_o && !prev) rises++;
      prev = step_o;
      if (rises == 3 && !step_o) break;
    end
    check("abort_pre_pulses", rises, 3);
    axi_write(5'h0C, 32'h4);
    check("abort_idle", {30'd0, busy_o, step_o}, 32'd0);
    bad_step = 1'b0; bad_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge aclk); #1;
      if (step_o || busy_o) bad_step = 1'b1;
      if (done_o) bad_done = 1'b1;
    end
    check("abort_stays_idle", {31'd0, bad_step}, 32'd0);
    check("abort_no_done", {31'd0, bad_done}, 32'd0);
    axi_read(5'h10, 32'd0);
    axi_read(5'h0C, 32'h0);

    // Write backpressure: BVALID held, a second request is not accepted
    bready = 1'b0;
    issue_write(5'h00, 32'h55, 4'hF);
    awaddr = 5'h04; wdata = 32'h66; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    bad_hold = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge aclk); #1;
      if (!bvalid || awready) bad_hold = 1'b1;
    end
    check("bp_write_hold", {31'd0, bad_hold}, 32'd0);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;

    // Read backpressure: RVALID held, a second request is not accepted
    rready = 1'b0;
    exp_r.push_back(32'h55);
    read_hold(5'h00);
    araddr = 5'h04; arvalid = 1'b1;
    bad_hold = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge aclk); #1;
      if (!rvalid || arready || rdata !== 32'h55) bad_hold = 1'b1;
    end
    check("bp_read_hold", {31'd0, bad_hold}, 32'd0);
    arvalid = 1'b0; rready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    axi_read(5'h04, 32'd2);

    // Simultaneous read and write
    fork
      axi_write(5'h04, 32'h77);
      axi_read(5'h00, 32'h55);
    join
    axi_read(5'h04, 32'h77);

    // Reset mid-move with a pending read response
    axi_write(5'h00, 32'd10);
    axi_write(5'h04, 32'd3);
    axi_write(5'h08, 32'd4);
    axi_write(5'h0C, 32'h3);
    repeat (4) @(posedge aclk);
    rready = 1'b0;
    read_hold(5'h10);
    check("pre_reset_state", {29'd0, rvalid, busy_o, dir_o}, 32'b111);
    areset = 1'b1;
    @(posedge aclk); #1;
    check("midmove_reset_outputs", {23'd0, awready, wready, bvalid, arready, rvalid, step_o, dir_o, busy_o, done_o}, 32'd0);
    areset = 1'b0; rready = 1'b1;
    axi_read(5'h00, 32'd0);
    axi_read(5'h0C, 32'd0);
    axi_read(5'h10, 32'd0);

    repeat (3) @(posedge aclk);
    #1;
    check("rd_queue_empty", 32'(exp_r.size()), 32'd0);
    check("wr_queue_empty", 32'(exp_b.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
